shift_register_univ: RTL and testbench
======================================

# shift_register_univ

Parametrised, synchronous successor to the team's single-bit D storage element. It is a WIDTH-bit edge-triggered register bank with eight operating modes: hold, parallel load, logical shifts, rotates, arithmetic shift right and clear. It provides complementary outputs, registered serial-out bits, and a saturating shift counter. It serves as the general storage/serialiser primitive for datapath and serial-link blocks.

## Interface
- WIDTH, 8, register width in bits; legal range 2 to 64.
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits).
- CW, $clog2(WIDTH+1), width of shift_cnt; derived, not overridden.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high; has priority over every other input.
- en  input  1  clock enable; 0 means all state holds.
- mode  input  3  operation select, sampled when en=1.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial bit entering the LSB on shift-left.
- sin_r  input  1  serial bit entering the MSB on shift-right.
- q  output  WIDTH  register contents.
- qn  output  WIDTH  ~q, combinational from q, no extra state.
- sout_l  output  1  registered copy of the last bit leaving the MSB.
- sout_r  output  1  registered copy of the last bit leaving the LSB.
- shift_cnt  output  CW  number of shift/rotate operations since the last load, clear or reset; saturates at WIDTH.
- full  output  1  high when shift_cnt == WIDTH.

## Operation
- Mode encoding, applied on a clk edge when en=1 and rst=0:
  - 000 hold: all state unchanged.
  - 001 load: q<=d; shift_cnt<=0.
  - 010 shl: q<={q[W-2:0],sin_l}; sout_l<=q[W-1].
  - 011 shr: q<={sin_r,q[W-1:1]}; sout_r<=q[0].
  - 100 rotl: q<={q[W-2:0],q[W-1]}; sout_l<=q[W-1].
  - 101 rotr: q<={q[0],q[W-1:1]}; sout_r<=q[0].
  - 110 asr: q<={q[W-1],q[W-1:1]}; sout_r<=q[0].
  - 111 clear: q<=0; shift_cnt<=0; sout_l and sout_r unchanged.
- Modes 010 to 110 increment shift_cnt by 1, saturating at WIDTH; it never wraps.
- Any sout bit not named for the active mode holds its value.
- full = (shift_cnt==WIDTH), combinational from the counter.
- en=0: q, sout_l, sout_r and shift_cnt all hold regardless of mode, d or the serial inputs.
- rst=1 at a clk edge sets q<=RESET_VAL, sout_l<=0, sout_r<=0, shift_cnt<=0. This applies regardless of en and mode, including mid-sequence.
- RESET_VAL affects only q. Clear mode always yields 0, not RESET_VAL.

## Timing
- Every state change takes effect at the rising clk edge. There are no level-sensitive (latch) paths.
- Latency: q, sout_l, sout_r and shift_cnt update one cycle after inputs are sampled. qn and full settle in the same cycle as q and shift_cnt.
- Inputs are sampled only at the edge. Glitches between edges have no effect.
- Reset values after the first edge with rst=1: q=RESET_VAL, qn=~RESET_VAL, sout_l=0, sout_r=0, shift_cnt=0, full=0.
- Outputs before the first reset edge are undefined. The bench must not check them.
- Back-to-back operations are supported on every cycle, with no bubbles.
- A load or clear on the cycle after saturation returns shift_cnt to 0 and full to 0 on the next edge.
- Shifting while full: the register still shifts, shift_cnt stays at WIDTH and full stays 1.

## Test plan
- Reset: RESET_VAL=8'hA5, rst=1 for 1 edge with en=0 -> q=8'hA5, qn=8'h5A, sout_l=0, sout_r=0, shift_cnt=0, full=0.
- Load then enable-hold: load 8'h3C; next cycle en=0, mode=010 -> q stays 8'h3C and shift_cnt stays 0.
- Shifts: from q=8'h81, one shl with sin_l=0 -> q=8'h02, sout_l=1, shift_cnt=1. Then one shr with sin_r=1 -> q=8'h81, sout_r=0, shift_cnt=2.
- Rotate and asr: from q=8'h81, rotl -> q=8'h03, sout_l=1. Reload 8'h81, rotr -> q=8'hC0, sout_r=1. Reload 8'h90, asr -> q=8'hC8, sout_r=0.
- Saturation: load 8'hFF, then 10 consecutive shl with sin_l=0 -> q=8'h00 after the 8th shift. shift_cnt reaches 8 and full=1 after the 8th shift, and both stay there through the 10th. A following clear -> q=0, shift_cnt=0, full=0.
- Reset mid-sequence: after 3 shl shifts, assert rst together with mode=001, d=8'hFF -> q=RESET_VAL, not 8'hFF; shift_cnt=0; sout_l=0.

Source files
------------

// File: rtl/shift_register_univ.sv
// Universal WIDTH-bit shift register: hold, load, logical shifts, rotates,
// arithmetic shift right and clear, with registered serial-out bits and a
// saturating count of shift/rotate operations since the last load/clear/reset.
module shift_register_univ #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  localparam int unsigned         CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    shift_cnt,
  output logic             full
);

  typedef enum logic [2:0] {
    ModeHold  = 3'b000,
    ModeLoad  = 3'b001,
    ModeShl   = 3'b010,
    ModeShr   = 3'b011,
    ModeRotl  = 3'b100,
    ModeRotr  = 3'b101,
    ModeAsr   = 3'b110,
    ModeClear = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CntMax = CW'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_l_q, sout_l_d;
  logic             sout_r_q, sout_r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cnt_inc;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  // Next-state decode; everything holds unless the selected mode changes it.
  always_comb begin
    q_d      = q_q;
    sout_l_d = sout_l_q;
    sout_r_d = sout_r_q;
    cnt_d    = cnt_q;
    cnt_inc  = 1'b0;
    if (en) begin
      unique case (mode_sel)
        ModeHold: ;
        ModeLoad: begin
          q_d   = d;
          cnt_d = '0;
        end
        ModeShl: begin
          q_d      = {q_q[WIDTH-2:0], sin_l};
          sout_l_d = q_q[WIDTH-1];
          cnt_inc  = 1'b1;
        end
        ModeShr: begin
          q_d      = {sin_r, q_q[WIDTH-1:1]};
          sout_r_d = q_q[0];
          cnt_inc  = 1'b1;
        end
        ModeRotl: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_l_d = q_q[WIDTH-1];
          cnt_inc  = 1'b1;
        end
        ModeRotr: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          sout_r_d = q_q[0];
          cnt_inc  = 1'b1;
        end
        ModeAsr: begin
          q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          sout_r_d = q_q[0];
          cnt_inc  = 1'b1;
        end
        ModeClear: begin
          // Clear always yields zero, independent of RESET_VAL.
          q_d   = '0;
          cnt_d = '0;
        end
        default: ;
      endcase
      // Counter saturates at WIDTH and never wraps.
      if (cnt_inc && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with synchronous, highest-priority reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q      <= RESET_VAL;
      sout_l_q <= 1'b0;
      sout_r_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      q_q      <= q_d;
      sout_l_q <= sout_l_d;
      sout_r_q <= sout_r_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs; qn and full are purely combinational from state.
  always_comb begin
    q         = q_q;
    qn        = ~q_q;
    sout_l    = sout_l_q;
    sout_r    = sout_r_q;
    shift_cnt = cnt_q;
    full      = (cnt_q == CntMax);
  end

endmodule

// File: tb/tb_shift_register_univ.sv
// Directed bench for shift_register_univ (WIDTH=8, RESET_VAL=8'hA5).
module tb_shift_register_univ;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             sout_l;
  logic             sout_r;
  logic [CW-1:0]    shift_cnt;
  logic             full;

  int tests = 0;
  int fails = 0;

  shift_register_univ #(
    .WIDTH    (WIDTH),
    .RESET_VAL(8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin_l    (sin_l),
    .sin_r    (sin_r),
    .q        (q),
    .qn       (qn),
    .sout_l   (sout_l),
    .sout_r   (sout_r),
    .shift_cnt(shift_cnt),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] dv, input logic sl, input logic sr);
    en    = 1'b1;
    mode  = m;
    d     = dv;
    sin_l = sl;
    sin_r = sr;
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;

    // Reset with en=0
    step();
    check("rst_q",      64'(q),         64'hA5);
    check("rst_qn",     64'(qn),        64'h5A);
    check("rst_sout_l", 64'(sout_l),    64'h0);
    check("rst_sout_r", 64'(sout_r),    64'h0);
    check("rst_cnt",    64'(shift_cnt), 64'h0);
    check("rst_full",   64'(full),      64'h0);
    rst = 1'b0;

    // Load, then en=0 with a shift mode must hold
    op(3'b001, 8'h3C, 1'b1, 1'b1);
    check("load_q",   64'(q),  64'h3C);
    check("load_qn",  64'(qn), 64'hC3);
    en = 1'b0; mode = 3'b010; d = 8'hFF; sin_l = 1'b1;
    step();
    check("en0_q",   64'(q),         64'h3C);
    check("en0_cnt", 64'(shift_cnt), 64'h0);
    op(3'b000, 8'h55, 1'b1, 1'b1);
    check("hold_q",  64'(q),         64'h3C);

    // shl then shr
    op(3'b001, 8'h81, 1'b0, 1'b0);
    op(3'b010, 8'h00, 1'b0, 1'b0);
    check("shl_q",      64'(q),         64'h02);
    check("shl_sout_l", 64'(sout_l),    64'h1);
    check("shl_cnt",    64'(shift_cnt), 64'h1);
    op(3'b011, 8'h00, 1'b0, 1'b1);
    check("shr_q",      64'(q),         64'h81);
    check("shr_sout_r", 64'(sout_r),    64'h0);
    check("shr_sout_l", 64'(sout_l),    64'h1);
    check("shr_cnt",    64'(shift_cnt), 64'h2);

    // Rotates and asr
    op(3'b001, 8'h81, 1'b0, 1'b0);
    op(3'b100, 8'h00, 1'b0, 1'b0);
    check("rotl_q",      64'(q),      64'h03);
    check("rotl_sout_l", 64'(sout_l), 64'h1);
    op(3'b001, 8'h81, 1'b0, 1'b0);
    op(3'b101, 8'h00, 1'b0, 1'b0);
    check("rotr_q",      64'(q),      64'hC0);
    check("rotr_sout_r", 64'(sout_r), 64'h1);
    op(3'b001, 8'h90, 1'b0, 1'b0);
    op(3'b110, 8'h00, 1'b0, 1'b1);
    check("asr_q",      64'(q),         64'hC8);
    check("asr_sout_r", 64'(sout_r),    64'h0);
    check("asr_cnt",    64'(shift_cnt), 64'h1);

    // Saturation: FF shifted left 10 times
    op(3'b001, 8'hFF, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) op(3'b010, 8'h00, 1'b0, 1'b0);
    check("sat7_q",    64'(q),         64'h80);
    check("sat7_cnt",  64'(shift_cnt), 64'h7);
    check("sat7_full", 64'(full),      64'h0);
    op(3'b010, 8'h00, 1'b0, 1'b0);
    check("sat8_q",    64'(q),         64'h00);
    check("sat8_cnt",  64'(shift_cnt), 64'h8);
    check("sat8_full", 64'(full),      64'h1);
    op(3'b010, 8'h00, 1'b0, 1'b0);
    op(3'b010, 8'h00, 1'b0, 1'b0);
    check("sat10_cnt",    64'(shift_cnt), 64'h8);
    check("sat10_full",   64'(full),      64'h1);
    check("sat10_sout_l", 64'(sout_l),    64'h0);
    op(3'b111, 8'hAA, 1'b1, 1'b1);
    check("clr_q",    64'(q),         64'h00);
    check("clr_cnt",  64'(shift_cnt), 64'h0);
    check("clr_full", 64'(full),      64'h0);

    // Clear keeps sout bits
    op(3'b001, 8'h01, 1'b0, 1'b0);
    op(3'b101, 8'h00, 1'b0, 1'b0);
    check("rotr2_q",  64'(q),      64'h80);
    op(3'b001, 8'hE0, 1'b0, 1'b0);
    op(3'b111, 8'h00, 1'b0, 1'b0);
    check("clr_sout_r", 64'(sout_r), 64'h1);

    // Reset mid-sequence overrides a simultaneous load
    op(3'b001, 8'hE0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) op(3'b010, 8'h00, 1'b0, 1'b0);
    check("pre_rst_q",      64'(q),         64'h00);
    check("pre_rst_sout_l", 64'(sout_l),    64'h1);
    check("pre_rst_cnt",    64'(shift_cnt), 64'h3);
    rst = 1'b1;
    op(3'b001, 8'hFF, 1'b0, 1'b0);
    rst = 1'b0;
    check("mid_rst_q",      64'(q),         64'hA5);
    check("mid_rst_cnt",    64'(shift_cnt), 64'h0);
    check("mid_rst_sout_l", 64'(sout_l),    64'h0);
    check("mid_rst_sout_r", 64'(sout_r),    64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
